// File: rtl/evm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | evm_pkg : shared state, frame and select encodings for the reader  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package evm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEL        = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_WIN        = 3'd3,
        ST_WIN_SETTLE = 3'd4,
        ST_TX_LOAD    = 3'd5,
        ST_TX_SHIFT   = 3'd6,
        ST_DONE       = 3'd7
    } evm_state_e;

    localparam logic [7:0] FRAME_HDR       = 8'hA5;
    localparam logic [1:0] SEL_NONE        = 2'd0;
    localparam int         WIN_INVALID_BIT = 7;
    localparam int         WIN_NAME_LSB    = 0;
    localparam int         WIN_NAME_W      = 2;

    function automatic logic [1:0] sel_cand(input int unsigned idx);
        return 2'(idx + 1);
    endfunction

    function automatic logic [7:0] winner_byte(input logic invalid, input logic [1:0] name);
        logic [7:0] b;
        b = 8'h00;
        b[WIN_INVALID_BIT] = invalid;
        b[WIN_NAME_LSB +: WIN_NAME_W] = name;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/evm_result_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | evm_result_reader_if : reader <-> voting core result interface     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface evm_result_reader_if #(
    parameter int COUNT_W = 7
);
    import evm_pkg::*;

    logic               voting_done;
    logic [COUNT_W-1:0] results;
    logic [1:0]         candidate_name;
    logic               invalid_results;
    logic [1:0]         display_sel;
    logic               winner_req;

    modport master (
        input  voting_done, results, candidate_name, invalid_results,
        output display_sel, winner_req
    );

    modport slave (
        output voting_done, results, candidate_name, invalid_results,
        input  display_sel, winner_req
    );
endinterface
`default_nettype wire

// File: rtl/evm_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | evm_uart_tx : 8N1 serializer, accepts a byte only while idle       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module evm_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire       clk,
    input  wire       rst_n,
    input  wire [7:0] data,
    input  wire       valid,
    output logic      ready,
    output logic      tx
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              busy_q, busy_d;
    logic [9:0]        shift_q, shift_d;
    logic [3:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;

    always_comb begin
        busy_d  = busy_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        if (!busy_q) begin
            if (valid) begin
                busy_d  = 1'b1;
                shift_d = {1'b1, data, 1'b0};
                bit_d   = 4'd0;
                baud_d  = BAUD_LAST;
            end
        end else if (bit_q == 4'd9 && baud_q == BAUD_W'(1)) begin
            // Stop bit leaves busy one clk early: the idle clk completes it and may load the next byte.
            busy_d = 1'b0;
        end else if (baud_q == '0) begin
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 4'd1;
            baud_d  = BAUD_LAST;
        end else begin
            baud_d = baud_q - BAUD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
            bit_q   <= 4'd0;
            baud_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

    assign ready = !busy_q;
    assign tx    = shift_q[0];
endmodule
`default_nettype wire

// File: rtl/evm_result_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | evm_result_reader : reads tallies/winner from core, emits a frame  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module evm_result_reader
    import evm_pkg::*;
#(
    parameter int NUM_CANDIDATES = 3,
    parameter int COUNT_W        = 7,
    parameter int CLKS_PER_BIT   = 16,
    parameter int SETTLE_CYCLES  = 2
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 start,
    evm_result_reader_if.master core,
    output logic                tx,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int N_BYTES  = NUM_CANDIDATES + 3;
    localparam int IDX_W    = (NUM_CANDIDATES > 1) ? $clog2(NUM_CANDIDATES) : 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int BYTE_W   = $clog2(N_BYTES + 1);

    evm_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [COUNT_W-1:0]  cnt_q [NUM_CANDIDATES];
    logic [COUNT_W-1:0]  cnt_d [NUM_CANDIDATES];
    logic [1:0]          name_q, name_d;
    logic                invalid_q, invalid_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [1:0]          display_sel_q, display_sel_d;
    logic                winner_req_q, winner_req_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]          tx_byte;
    logic                uart_valid, uart_ready;

    always_comb begin
        tx_byte = FRAME_HDR;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (byte_idx_q == BYTE_W'(i + 1)) tx_byte = 8'(cnt_q[i]);
        end
        if (byte_idx_q == BYTE_W'(NUM_CANDIDATES + 1))      tx_byte = winner_byte(invalid_q, name_q);
        else if (byte_idx_q == BYTE_W'(NUM_CANDIDATES + 2)) tx_byte = csum_q;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        settle_d      = settle_q;
        cnt_d         = cnt_q;
        name_d        = name_q;
        invalid_d     = invalid_q;
        byte_idx_d    = byte_idx_q;
        csum_d        = csum_q;
        display_sel_d = display_sel_q;
        winner_req_d  = winner_req_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        uart_valid    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                if (core.voting_done) begin
                    state_d = ST_SEL;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_SEL: begin
                display_sel_d = sel_cand(32'(idx_q));
                settle_d      = SETTLE_W'(SETTLE_CYCLES - 1);
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: if (settle_q == '0) begin
                for (int i = 0; i < NUM_CANDIDATES; i++) begin
                    if (idx_q == IDX_W'(i)) cnt_d[i] = core.results;
                end
                if (idx_q < IDX_W'(NUM_CANDIDATES - 1)) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SEL;
                end else begin
                    state_d = ST_WIN;
                end
            end else begin
                settle_d = settle_q - SETTLE_W'(1);
            end
            ST_WIN: begin
                display_sel_d = SEL_NONE;
                winner_req_d  = 1'b1;
                settle_d      = SETTLE_W'(SETTLE_CYCLES - 1);
                state_d       = ST_WIN_SETTLE;
            end
            ST_WIN_SETTLE: if (settle_q == '0) begin
                name_d       = core.candidate_name;
                invalid_d    = core.invalid_results;
                winner_req_d = 1'b0;
                byte_idx_d   = '0;
                csum_d       = 8'h00;
                state_d      = ST_TX_LOAD;
            end else begin
                settle_d = settle_q - SETTLE_W'(1);
            end
            ST_TX_LOAD: begin
                uart_valid = 1'b1;
                if (uart_ready) begin
                    csum_d     = csum_q ^ tx_byte;
                    byte_idx_d = byte_idx_q + BYTE_W'(1);
                    state_d    = ST_TX_SHIFT;
                end
            end
            // Next byte is offered while the current one shifts, so the UART chains them gap-free.
            ST_TX_SHIFT: if (byte_idx_q != BYTE_W'(N_BYTES)) begin
                state_d = ST_TX_LOAD;
            end else if (uart_ready) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q inside {ST_SEL, ST_SETTLE, ST_WIN, ST_WIN_SETTLE} && !core.voting_done) begin
            state_d       = ST_IDLE;
            err_d         = 1'b1;
            display_sel_d = SEL_NONE;
            winner_req_d  = 1'b0;
            busy_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            settle_q      <= '0;
            cnt_q         <= '{default: '0};
            name_q        <= 2'd0;
            invalid_q     <= 1'b0;
            byte_idx_q    <= '0;
            csum_q        <= 8'h00;
            display_sel_q <= SEL_NONE;
            winner_req_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            settle_q      <= settle_d;
            cnt_q         <= cnt_d;
            name_q        <= name_d;
            invalid_q     <= invalid_d;
            byte_idx_q    <= byte_idx_d;
            csum_q        <= csum_d;
            display_sel_q <= display_sel_d;
            winner_req_q  <= winner_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    evm_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (tx_byte),
        .valid (uart_valid),
        .ready (uart_ready),
        .tx    (tx)
    );

    assign core.display_sel = display_sel_q;
    assign core.winner_req  = winner_req_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
endmodule
`default_nettype wire

// File: tb/tb_evm_result_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_evm_result_reader : frame scoreboard bench for evm_result_reader |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_evm_result_reader;
    localparam int CPB    = 16;
    localparam int BIT_T  = CPB * 10;
    localparam int BYTE_T = BIT_T * 10;

    typedef struct {
        logic [6:0] c0, c1, c2;
        logic [1:0] name;
        logic       inv;
        logic [7:0] csum;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic tx, busy, done, err;
    logic [6:0] tally [3];
    logic [6:0] res_r;
    logic [1:0] w_name = 2'd0;
    logic       w_inv = 1'b0;
    logic [7:0] sb [$];
    logic [1:0] sel_log [$];
    logic [1:0] last_sel = 2'd0;
    vec_t       vecs [4];
    int         n_vec = 0, n_fail = 0, rx_count = 0;
    bit         rst_seen = 1'b0;
    time        prev_edge = 0;

    evm_result_reader_if #(.COUNT_W(7)) core_if ();

    evm_result_reader #(.NUM_CANDIDATES(3), .COUNT_W(7), .CLKS_PER_BIT(CPB), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .core  (core_if),
        .tx    (tx),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Core model: tally appears one clk after the select changes; winner fields are garbage unless requested.
    always @(posedge clk) begin
        case (core_if.display_sel)
            2'd1:    res_r <= tally[0];
            2'd2:    res_r <= tally[1];
            2'd3:    res_r <= tally[2];
            default: res_r <= 7'h55;
        endcase
    end
    assign core_if.results         = res_r;
    assign core_if.candidate_name  = core_if.winner_req ? w_name : ~w_name;
    assign core_if.invalid_results = core_if.winner_req ? w_inv : ~w_inv;

    always @(negedge clk) begin
        if (core_if.display_sel != last_sel && core_if.display_sel != 2'd0)
            sel_log.push_back(core_if.display_sel);
        last_sel <= core_if.display_sel;
    end

    always @(negedge rst_n) rst_seen = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Serial receiver: samples bit centres and checks each byte against the scoreboard.
    initial begin : rx
        logic [7:0] b;
        logic       sbit, pbit;
        logic [7:0] exp_b;
        time        t_edge;
        forever begin
            @(negedge tx);
            if (rst_n) begin
                t_edge   = $time;
                rst_seen = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                sbit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                pbit = tx;
                if (!rst_seen) begin
                    chk("rx_start_bit", 32'(sbit), 32'd0);
                    chk("rx_stop_bit", 32'(pbit), 32'd1);
                    if (rx_count > 0) chk("rx_no_gap", 32'(t_edge - prev_edge), 32'(BYTE_T));
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL rx_unexpected_byte: got %0h expected none", b);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("rx_byte", 32'(b), 32'(exp_b));
                    end
                    prev_edge = t_edge;
                    rx_count++;
                end
            end
        end
    end

    task automatic apply(input vec_t v);
        tally[0] = v.c0;
        tally[1] = v.c1;
        tally[2] = v.c2;
        w_name   = v.name;
        w_inv    = v.inv;
        sb.push_back(8'hA5);
        sb.push_back({1'b0, v.c0});
        sb.push_back({1'b0, v.c1});
        sb.push_back({1'b0, v.c2});
        sb.push_back({v.inv, 5'b00000, v.name});
        sb.push_back(v.csum);
        rx_count = 0;
        sel_log.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input bit extra_starts);
        int cyc;
        bit seen_done, quiet;
        apply(v);
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        cyc = 1;
        seen_done = 1'b0;
        while (cyc < 3000 && !seen_done) begin
            @(negedge clk);
            cyc++;
            if (extra_starts) start = (cyc % 300 == 150);
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("done_latency", 32'(cyc >= 960 && cyc <= 1000), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("tx_idle_at_done", 32'(tx), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        quiet = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (busy || !tx) quiet = 1'b0;
        end
        chk("quiet_after_frame", 32'(quiet), 32'd1);
        chk("frame_bytes", 32'(rx_count), 32'd6);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("sel_count", 32'(sel_log.size()), 32'd3);
        if (sel_log.size() == 3) chk("sel_seq", 32'({sel_log[0], sel_log[1], sel_log[2]}), 32'h1B);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found, quiet;
        vecs[0] = '{c0: 7'h05, c1: 7'h03, c2: 7'h09, name: 2'd3, inv: 1'b0, csum: 8'hA9};
        vecs[1] = '{c0: 7'h7F, c1: 7'h7F, c2: 7'h00, name: 2'd0, inv: 1'b1, csum: 8'h25};
        vecs[2] = '{c0: 7'h00, c1: 7'h00, c2: 7'h00, name: 2'd1, inv: 1'b0, csum: 8'hA4};
        vecs[3] = '{c0: 7'h12, c1: 7'h34, c2: 7'h56, name: 2'd2, inv: 1'b0, csum: 8'hD7};
        tally[0] = 7'h0; tally[1] = 7'h0; tally[2] = 7'h0;
        core_if.voting_done = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({core_if.display_sel, core_if.winner_req, tx, busy, done, err}), 32'b00_0_1_000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0);

        // Start rejected while voting is still open.
        core_if.voting_done = 1'b0;
        pulse_start();
        chk("err_pulse", 32'(err), 32'd1);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy || !tx || err || core_if.display_sel != 2'd0) quiet = 1'b0;
        end
        chk("reject_quiet", 32'(quiet), 32'd1);

        // voting_done drops while candidate 2 is settling.
        core_if.voting_done = 1'b1;
        tally[0] = 7'h11; tally[1] = 7'h22; tally[2] = 7'h33;
        rx_count = 0;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (core_if.display_sel == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reach_sel2", 32'(found), 32'd1);
        core_if.voting_done = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({core_if.display_sel, core_if.winner_req, tx, busy, err}), 32'b00_0_1_0_1);
        @(negedge clk);
        chk("abort_err_one_cycle", 32'(err), 32'd0);
        quiet = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (busy || !tx || core_if.display_sel != 2'd0) quiet = 1'b0;
        end
        chk("abort_quiet", 32'(quiet), 32'd1);
        chk("abort_no_bytes", 32'(rx_count), 32'd0);
        core_if.voting_done = 1'b1;
        repeat (3) @(negedge clk);

        // Start pulses while the frame is shifting out.
        run_frame(vecs[0], 1'b1);

        // Reset during byte 3, then a fresh frame.
        apply(vecs[1]);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (rx_count == 3) found = 1'b1;
        end
        chk("rst_reach_byte3", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (!tx) found = 1'b1;
        end
        chk("rst_byte3_started", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", 32'({core_if.display_sel, core_if.winner_req, tx, busy, done, err}), 32'b00_0_1_000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        repeat (250) @(negedge clk);
        chk("rst_no_extra_bytes", 32'(rx_count), 32'd3);
        run_frame(vecs[3], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
